// File: rtl/exc_commit_unit_pkg.sv
// Shared definitions for the writeback exception commit unit: bit positions,
// CP0 ExcCode values, the exception vector and the small enums used at top level.
package exc_commit_unit_pkg;

    localparam int EXC_TYPE_W = 7;
    localparam int FLAGS_W    = 7;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

    // exc_type bus bit positions, ordered {int, adel, ades, sys, bp, ri, ov}
    localparam int INT_BIT  = 6;
    localparam int ADEL_BIT = 5;
    localparam int ADES_BIT = 4;
    localparam int SYS_BIT  = 3;
    localparam int BP_BIT   = 2;
    localparam int RI_BIT   = 1;
    localparam int OV_BIT   = 0;

    // ws_exc_flags bit positions, ordered {adel_if, ri, ov, sys, bp, adel_ld, ades}
    localparam int F_ADEL_IF = 6;
    localparam int F_RI      = 5;
    localparam int F_OV      = 4;
    localparam int F_SYS     = 3;
    localparam int F_BP      = 2;
    localparam int F_ADEL_LD = 1;
    localparam int F_ADES    = 0;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    typedef enum logic [1:0] {
        VADDR_NONE = 2'd0,
        VADDR_PC   = 2'd1,
        VADDR_MEM  = 2'd2
    } vaddr_sel_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_e;

endpackage

// File: rtl/exc_prio_sel.sv
// Fixed-priority one-hot exception selector: int > adel_if > ri > ov > sys > bp
// > adel_ld > ades, plus which address feeds bad_vaddr.
module exc_prio_sel
    import exc_commit_unit_pkg::*;
(
    input  logic                  take_int,
    input  logic [FLAGS_W-1:0]    flags,
    output logic [EXC_TYPE_W-1:0] exc_type,
    output vaddr_sel_e            vaddr_sel
);

    // Priority chain; both address-error-on-load sources share the adel bit
    always_comb begin
        exc_type  = {EXC_TYPE_W{1'b0}};
        vaddr_sel = VADDR_NONE;
        if (take_int) begin
            exc_type[INT_BIT] = 1'b1;
        end else if (flags[F_ADEL_IF]) begin
            exc_type[ADEL_BIT] = 1'b1;
            vaddr_sel          = VADDR_PC;
        end else if (flags[F_RI]) begin
            exc_type[RI_BIT] = 1'b1;
        end else if (flags[F_OV]) begin
            exc_type[OV_BIT] = 1'b1;
        end else if (flags[F_SYS]) begin
            exc_type[SYS_BIT] = 1'b1;
        end else if (flags[F_BP]) begin
            exc_type[BP_BIT] = 1'b1;
        end else if (flags[F_ADEL_LD]) begin
            exc_type[ADEL_BIT] = 1'b1;
            vaddr_sel          = VADDR_MEM;
        end else if (flags[F_ADES]) begin
            exc_type[ADES_BIT] = 1'b1;
            vaddr_sel          = VADDR_MEM;
        end else begin
            exc_type  = {EXC_TYPE_W{1'b0}};
            vaddr_sel = VADDR_NONE;
        end
    end

endmodule

// File: rtl/exc_commit_unit.sv
// Writeback exception/interrupt commit unit: reports the committing exception
// or ERET to CP0, flushes the pipe and holds a fetch redirect until accepted.
module exc_commit_unit
    import exc_commit_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          EXC_W      = EXC_TYPE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ws_valid,
    output logic               ws_allowin,
    input  logic [31:0]        ws_pc,
    input  logic               ws_is_slot,
    input  logic [FLAGS_W-1:0] ws_exc_flags,
    input  logic               ws_eret,
    input  logic [31:0]        ws_mem_vaddr,
    output logic               ws_kill_wen,
    input  logic               int_happen,
    input  logic [31:0]        cp0_epc,
    output logic [EXC_W-1:0]   exc_type,
    output logic [31:0]        exc_pc,
    output logic               exc_is_slot,
    output logic [31:0]        bad_vaddr,
    output logic               eret,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    input  logic               redirect_ready
);

    state_e      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        int_q, int_d;

    logic                  take_int_s;
    logic                  commit_s;
    logic                  has_exc_s;
    logic                  eret_s;
    logic [EXC_TYPE_W-1:0] sel_type_s;
    vaddr_sel_e            vaddr_sel_s;

    // A request must be seen on two consecutive cycles, dropping one that CP0
    // already withdrew after EXL went up.
    assign take_int_s = int_q & int_happen;

    exc_prio_sel u_prio_sel (
        .take_int  (take_int_s),
        .flags     (ws_exc_flags),
        .exc_type  (sel_type_s),
        .vaddr_sel (vaddr_sel_s)
    );

    // Commit-cycle decode of the CP0-facing outputs
    always_comb begin
        commit_s    = 1'b0;
        ws_allowin  = 1'b0;
        has_exc_s   = 1'b0;
        eret_s      = 1'b0;
        exc_type    = {EXC_W{1'b0}};
        exc_pc      = 32'h0000_0000;
        exc_is_slot = 1'b0;
        bad_vaddr   = 32'h0000_0000;
        ws_kill_wen = 1'b0;
        if (!rst && (state_q == S_IDLE)) begin
            ws_allowin = 1'b1;
            commit_s   = ws_valid;
        end else begin
            ws_allowin = 1'b0;
            commit_s   = 1'b0;
        end
        if (commit_s) begin
            has_exc_s   = |sel_type_s;
            eret_s      = ws_eret & ~has_exc_s;
            exc_type    = sel_type_s;
            exc_pc      = ws_pc;
            exc_is_slot = ws_is_slot;
            ws_kill_wen = has_exc_s;
            case (vaddr_sel_s)
                VADDR_PC:   bad_vaddr = ws_pc;
                VADDR_MEM:  bad_vaddr = ws_mem_vaddr;
                VADDR_NONE: bad_vaddr = 32'h0000_0000;
                default:    bad_vaddr = 32'h0000_0000;
            endcase
        end else begin
            has_exc_s = 1'b0;
            eret_s    = 1'b0;
        end
    end

    assign eret = eret_s;

    // Redirect FSM next-state, target capture and flush
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        int_d         = int_happen;
        flush         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (commit_s && has_exc_s) begin
                    flush         = 1'b1;
                    state_d       = S_REDIRECT;
                    redirect_pc_d = EXC_VECTOR;
                end else if (commit_s && eret_s) begin
                    flush         = 1'b1;
                    state_d       = S_REDIRECT;
                    redirect_pc_d = cp0_epc;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIRECT: begin
                flush = ~rst;
                if (redirect_valid_q && redirect_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REDIRECT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        redirect_valid_d = (state_d == S_REDIRECT);
    end

    // Synchronous reset clears any pending redirect and the interrupt filter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0000_0000;
            int_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            int_q            <= int_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
